// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream FIFO reader: the reader FSM encoding,
// the output buffer depth and a ceil(log2) helper for sizing occupancy counts.
package axis_pkg;

   // Reader FSM: IDLE waits for a start, RUN issues pops, DRAIN empties the buffer
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fsm_state_t;

   // Entries in the output buffer (head + skid); covers the FIFO's 1-cycle read latency
   localparam int BUF_DEPTH = 2;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Width of an occupancy count that can hold 0..BUF_DEPTH
   localparam int OCC_W = clogb2(BUF_DEPTH + 1);

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output buffer (head + skid) driving an AXI4-Stream master.
// The head register is the visible beat; the skid entry catches a word that
// arrives while the head is stalled. All outputs are registered.
module axis_skid_buffer
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic [OCC_W-1:0]      occ
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } beat_t;

   beat_t head_q;
   beat_t skid_q;
   beat_t in_beat;
   logic  head_vld;
   logic  skid_vld;
   logic  hs;

   assign in_beat   = '{data: in_data, last: in_last};
   assign hs        = head_vld && out_ready;
   assign out_valid = head_vld;
   assign out_data  = head_q.data;
   assign out_last  = head_q.last;
   assign occ       = OCC_W'(head_vld) + OCC_W'(skid_vld);

   // Head/skid update: a handshake advances the skid into the head, a write fills the first free slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q   <= '0;
         skid_q   <= '0;
         head_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (hs) begin
         if (skid_vld) begin
            head_q <= skid_q;
            if (in_valid) skid_q <= in_beat;
            else          skid_vld <= 1'b0;
         end else if (in_valid) begin
            head_q <= in_beat;
         end else begin
            head_vld <= 1'b0;
         end
      end else if (in_valid) begin
         if (!head_vld) begin
            head_q   <= in_beat;
            head_vld <= 1'b1;
         end else begin
            skid_q   <= in_beat;
            skid_vld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_fifo_reader.sv
// Drains a registered-output FIFO into an AXI4-Stream master, one packet of
// pkt_len words per start pulse, with tlast on the final beat. Pops are
// throttled so that buffered plus in-flight words never exceed the buffer.
module axis_fifo_reader
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [LEN_WIDTH-1:0]    pkt_len,
   output logic                    busy,
   output logic                    done,
   input  logic                    fifo_empty,
   input  logic [DATA_WIDTH-1:0]   fifo_data,
   output logic                    fifo_pop,
   output logic                    m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   fsm_state_t           state;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] pop_cnt;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic                 pend_p1;
   logic                 pend_last_p1;
   logic [OCC_W-1:0]     occ;
   logic                 hs;
   logic                 last_pop;
   logic [OCC_W:0]       committed;
   logic [OCC_W:0]       room_limit;

   assign hs           = m_axis_tvalid && m_axis_tready;
   assign last_pop     = (pop_cnt == len_q - LEN_ONE);
   // Words already owed to the buffer: stored entries plus the one arriving from last cycle's pop
   assign committed    = (OCC_W+1)'(occ) + (OCC_W+1)'(pend_p1);
   // A handshake this cycle frees one slot in time for a word popped now
   assign room_limit   = (OCC_W+1)'(BUF_DEPTH) + (OCC_W+1)'(hs);
   assign fifo_pop     = (state == RUN) && !fifo_empty && (pop_cnt < len_q) &&
                         (committed < room_limit);
   assign m_axis_tstrb = {(DATA_WIDTH/8){m_axis_tvalid}};

   // Packet control FSM with counters and registered busy/done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         len_q    <= '0;
         pop_cnt  <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fifo_pop) pop_cnt  <= pop_cnt + LEN_ONE;
         if (hs)       beat_cnt <= beat_cnt + LEN_ONE;
         case (state)
            IDLE: begin
               if (start && (pkt_len != '0)) begin
                  len_q    <= pkt_len;
                  pop_cnt  <= '0;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (fifo_pop && last_pop) state <= DRAIN;
            end
            DRAIN: begin
               if (hs && (beat_cnt == len_q - LEN_ONE)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---- stage p1: FIFO read data is valid; remember the pop and whether it was the last word ----
   // Track the pop issued last cycle and its tlast flag, so the word is written next cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_p1      <= 1'b0;
         pend_last_p1 <= 1'b0;
      end else begin
         pend_p1      <= fifo_pop;
         pend_last_p1 <= fifo_pop && last_pop;
      end
   end

   // ---- stage p2: buffered beat presented on the AXIS port ----
   axis_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (pend_p1),
      .in_data   (fifo_data),
      .in_last   (pend_last_p1),
      .out_valid (m_axis_tvalid),
      .out_data  (m_axis_tdata),
      .out_last  (m_axis_tlast),
      .out_ready (m_axis_tready),
      .occ       (occ)
   );

endmodule

// File: tb/tb_axis_fifo_reader.sv
// Bench for axis_fifo_reader: behavioural FIFO, packet-level scoreboard checked
// every cycle, and directed scenarios with hand-computed timing expectations.
`timescale 1ns/1ps
module tb_axis_fifo_reader;

   localparam int DW = 32;
   localparam int LW = 16;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b0;
   logic [LW-1:0]   pkt_len = '0;
   logic            busy;
   logic            done;
   logic            fifo_empty = 1'b1;
   logic [DW-1:0]   fifo_data = '0;
   logic            fifo_pop;
   logic            m_axis_tvalid;
   logic [DW-1:0]   m_axis_tdata;
   logic [DW/8-1:0] m_axis_tstrb;
   logic            m_axis_tlast;
   logic            m_axis_tready = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   // Bench FIFO storage, words waiting to enter it, and the expected output order
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] push_q[$];
   logic [DW-1:0] exp_q[$];
   logic          pop_s = 1'b0;

   // Backpressure pattern 1,0,0,1 (bit i used on cycle i mod 4)
   logic [3:0] bp_pat = 4'b1001;
   int         bp_mode = 0;
   int         cyc = 0;

   // Packet-level model
   logic          m_busy = 1'b0;
   logic          m_busy_n;
   logic          m_done = 1'b0;
   logic          m_done_n;
   int            m_len = 0;
   int            m_beat = 0;
   int            m_pops = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   int            beats_tot = 0;
   int            done_tot = 0;

   axis_fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .pkt_len       (pkt_len),
      .busy          (busy),
      .done          (done),
      .fifo_empty    (fifo_empty),
      .fifo_data     (fifo_data),
      .fifo_pop      (fifo_pop),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      push_q.push_back(w);
      exp_q.push_back(w);
   endtask

   // FIFO with a registered output: data appears the cycle after a pop
   always @(posedge clk) begin
      if (!reset_n) begin
         fifo_q.delete();
         push_q.delete();
         fifo_empty <= 1'b1;
      end else begin
         if (pop_s && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
         while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
         fifo_empty <= (fifo_q.size() == 0);
      end
   end

   // Ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         m_axis_tready = (bp_mode == 0) ? 1'b1 : bp_pat[cyc % 4];
      end
   end

   // Per-cycle compare against the packet-level model
   always @(negedge clk) begin
      if (!reset_n) begin
         m_busy     = 1'b0;
         m_done     = 1'b0;
         prev_stall = 1'b0;
         pop_s      = 1'b0;
         exp_q.delete();
      end else begin
         m_busy_n = m_busy;
         m_done_n = 1'b0;
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("tstrb", m_axis_tstrb, {(DW/8){m_axis_tvalid}});
         if (prev_stall) begin
            chk("hold_tvalid", m_axis_tvalid, 1'b1);
            chk("hold_tdata", m_axis_tdata, prev_data);
            chk("hold_tlast", m_axis_tlast, prev_last);
         end
         if (!m_busy) begin
            chk("idle_tvalid", m_axis_tvalid, 1'b0);
            chk("idle_pop", fifo_pop, 1'b0);
         end
         if (fifo_pop) begin
            chk("pop_when_empty", fifo_empty, 1'b0);
            m_pops++;
            chk("pop_over_len", (m_pops <= m_len), 1'b1);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            beats_tot++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL beat_unexpected: got tdata 0x%0h, expected no beat", m_axis_tdata);
            end else begin
               chk("tdata", m_axis_tdata, exp_q.pop_front());
               chk("tlast", m_axis_tlast, (m_beat == m_len - 1));
               if (m_beat == m_len - 1) begin
                  chk("pop_total", m_pops, m_len);
                  m_busy_n = 1'b0;
                  m_done_n = 1'b1;
               end
               m_beat++;
            end
         end
         if (start && !m_busy && pkt_len != '0) begin
            m_busy_n = 1'b1;
            m_len    = int'(pkt_len);
            m_beat   = 0;
            m_pops   = 0;
         end
         if (done) done_tot++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
         pop_s      = fifo_pop;
         m_busy     = m_busy_n;
         m_done     = m_done_n;
      end
   end

   task automatic do_start(input int len);
      @(posedge clk); #1;
      start   = 1'b1;
      pkt_len = LW'(len);
      @(posedge clk); #1;
      start   = 1'b0;
      pkt_len = '0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int n;
      d0 = done_tot;
      n  = 0;
      while (done_tot == d0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      chk("done_seen", (done_tot != d0), 1'b1);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int b0;
      int d0;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_tdata", m_axis_tdata, '0);
      chk("rst_tlast", m_axis_tlast, 1'b0);
      chk("rst_tstrb", m_axis_tstrb, '0);
      chk("rst_pop", fifo_pop, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      settle(2);

      // Basic packet: A0..A3, latency start->tvalid of 3 cycles
      for (int i = 0; i < 4; i++) push_word(32'hA0 + i);
      settle(2);
      do_start(4);
      @(negedge clk);
      chk("basic_pop_t1", fifo_pop, 1'b1);
      chk("basic_busy_t1", busy, 1'b1);
      chk("basic_tvalid_t1", m_axis_tvalid, 1'b0);
      @(negedge clk);
      chk("basic_tvalid_t2", m_axis_tvalid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("basic_tvalid", m_axis_tvalid, 1'b1);
         chk("basic_tdata", m_axis_tdata, 32'hA0 + i);
         chk("basic_tlast", m_axis_tlast, (i == 3));
      end
      @(negedge clk);
      chk("basic_done", done, 1'b1);
      chk("basic_busy_end", busy, 1'b0);
      chk("basic_tvalid_end", m_axis_tvalid, 1'b0);
      @(negedge clk);
      chk("basic_done_pulse", done, 1'b0);
      settle(2);

      // Backpressure: 8 words, ready 1,0,0,1...
      b0 = beats_tot;
      for (int i = 0; i < 8; i++) push_word(32'h10 + i);
      settle(2);
      bp_mode = 1;
      do_start(8);
      wait_done(200);
      bp_mode = 0;
      chk("bp_beats", beats_tot - b0, 8);
      settle(3);

      // FIFO underflow: 2 words, then 3 more about 10 cycles later
      b0 = beats_tot;
      push_word(32'h20);
      push_word(32'h21);
      settle(2);
      do_start(5);
      repeat (8) @(negedge clk);
      chk("uf_gap_tvalid", m_axis_tvalid, 1'b0);
      chk("uf_gap_busy", busy, 1'b1);
      chk("uf_gap_pop", fifo_pop, 1'b0);
      chk("uf_gap_beats", beats_tot - b0, 2);
      settle(1);
      for (int i = 2; i < 5; i++) push_word(32'h20 + i);
      wait_done(100);
      chk("uf_beats", beats_tot - b0, 5);
      settle(3);

      // Edge lengths: length 0 ignored, then length 1
      push_word(32'hB0);
      settle(2);
      do_start(0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("len0_busy", busy, 1'b0);
         chk("len0_pop", fifo_pop, 1'b0);
      end
      do_start(1);
      repeat (2) @(negedge clk);
      @(negedge clk);
      chk("len1_tvalid", m_axis_tvalid, 1'b1);
      chk("len1_tdata", m_axis_tdata, 32'hB0);
      chk("len1_tlast", m_axis_tlast, 1'b1);
      @(negedge clk);
      chk("len1_done", done, 1'b1);
      settle(3);

      // Start while busy: second start with length 3 is ignored
      b0 = beats_tot;
      d0 = done_tot;
      for (int i = 0; i < 6; i++) push_word(32'h30 + i);
      settle(2);
      do_start(6);
      settle(1);
      start   = 1'b1;
      pkt_len = LW'(3);
      settle(1);
      start   = 1'b0;
      pkt_len = '0;
      wait_done(100);
      settle(10);
      chk("busy_start_beats", beats_tot - b0, 6);
      chk("busy_start_dones", done_tot - d0, 1);
      chk("busy_start_idle", busy, 1'b0);

      // Reset mid-packet after beat 2 of 6
      b0 = beats_tot;
      for (int i = 0; i < 6; i++) push_word(32'h40 + i);
      settle(2);
      do_start(6);
      n = 0;
      while ((beats_tot - b0) < 2 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      chk("rstmid_reached", ((beats_tot - b0) >= 2), 1'b1);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_done", done, 1'b0);
      chk("rstmid_tvalid", m_axis_tvalid, 1'b0);
      chk("rstmid_tdata", m_axis_tdata, '0);
      chk("rstmid_tlast", m_axis_tlast, 1'b0);
      chk("rstmid_tstrb", m_axis_tstrb, '0);
      chk("rstmid_pop", fifo_pop, 1'b0);
      settle(3);
      reset_n = 1'b1;
      d0 = done_tot;
      repeat (4) @(negedge clk);
      #1;
      chk("rstmid_no_done", done_tot - d0, 0);
      b0 = beats_tot;
      for (int i = 0; i < 3; i++) push_word(32'hD0 + i);
      settle(2);
      do_start(3);
      wait_done(100);
      chk("rstmid_fresh_beats", beats_tot - b0, 3);
      settle(3);
      chk("leftover_expected", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
